// File: rtl/serial_adder.sv
// Bit-serial ripple adder: streams two WIDTH-bit operands LSB-first through a
// single full-adder stage, recirculating its carry, and registers the result.

module fulladder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic S,
  output logic C_out
);

  assign S     = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));

endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A_IN,
  input  logic [WIDTH-1:0] B_IN,
  input  logic             C_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             C_OUT
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] sum_shift;
  logic             cy_q, cy_d;
  logic             c_out_q, c_out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s;
  logic             fa_c;

  fulladder u_fa (
    .A     (a_sh_q[0]),
    .B     (b_sh_q[0]),
    .C_in  (cy_q),
    .S     (fa_s),
    .C_out (fa_c)
  );

  // Each new sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at SUM[0].
  generate
    if (WIDTH == 1) begin : g_sum_w1
      assign sum_shift = fa_s;
    end else begin : g_sum_wn
      assign sum_shift = {fa_s, sum_q[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (START) begin
          a_sh_d  = A_IN;
          b_sh_d  = B_IN;
          cy_d    = C_IN;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_d  = sum_shift;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cy_d   = fa_c;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          c_out_d = fa_c;
          state_d = S_FIN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY  = (state_q == S_RUN);
  assign DONE  = (state_q == S_FIN);
  assign SUM   = sum_q;
  assign C_OUT = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 and WIDTH=1 instances against a
// cycle-level arithmetic model, plus directed literal results.

module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [2];
  logic       start [2];
  logic [7:0] a_in  [2];
  logic [7:0] b_in  [2];
  logic       c_in  [2];

  logic       busy8, done8, cout8;
  logic [7:0] sum8;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  logic       obs_busy [2];
  logic       obs_done [2];
  logic       obs_cout [2];
  logic [7:0] obs_sum  [2];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  serial_adder #(.WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst[0]), .START(start[0]),
    .A_IN(a_in[0]), .B_IN(b_in[0]), .C_IN(c_in[0]),
    .BUSY(busy8), .DONE(done8), .SUM(sum8), .C_OUT(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .CLK(clk), .RST(rst[1]), .START(start[1]),
    .A_IN(a_in[1][0:0]), .B_IN(b_in[1][0:0]), .C_IN(c_in[1]),
    .BUSY(busy1), .DONE(done1), .SUM(sum1), .C_OUT(cout1)
  );

  always_comb begin
    obs_busy[0] = busy8;
    obs_done[0] = done8;
    obs_cout[0] = cout8;
    obs_sum[0]  = sum8;
    obs_busy[1] = busy1;
    obs_done[1] = done1;
    obs_cout[1] = cout1;
    obs_sum[1]  = {7'd0, sum1};
  end

  function automatic int wid(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  // Reference result {carry, sum} of a W-bit add, from plain integer arithmetic.
  function automatic logic [8:0] ref_add(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic c);
    int unsigned m, r;
    m = (1 << w) - 1;
    r = (a & m) + (b & m) + c;
    return {(r >> w) & 1, 8'(r & m)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Behavioural model: an accepted start yields W busy cycles, then one done
  // cycle with the arithmetic result; the carry output holds until then.
  int         m_left [2] = '{0, 0};
  logic       m_done [2] = '{0, 0};
  logic [7:0] m_sum  [2] = '{0, 0};
  logic       m_cout [2] = '{0, 0};
  logic [8:0] m_pend [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst[i]) begin
        m_left[i] <= 0;
        m_done[i] <= 1'b0;
        m_sum[i]  <= '0;
        m_cout[i] <= 1'b0;
      end else if (m_left[i] > 0) begin
        m_left[i] <= m_left[i] - 1;
        m_done[i] <= (m_left[i] == 1);
        if (m_left[i] == 1) begin
          m_sum[i]  <= m_pend[i][7:0];
          m_cout[i] <= m_pend[i][8];
        end
      end else begin
        m_done[i] <= 1'b0;
        if (start[i]) begin
          m_pend[i] <= ref_add(wid(i), a_in[i], b_in[i], c_in[i]);
          m_left[i] <= wid(i);
          m_sum[i]  <= '0;
        end
      end
    end
  end

  // Per-cycle comparison, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("cyc_busy[%0d]", i), 32'(obs_busy[i]), 32'(m_left[i] > 0));
        chk($sformatf("cyc_done[%0d]", i), 32'(obs_done[i]), 32'(m_done[i]));
        chk($sformatf("cyc_cout[%0d]", i), 32'(obs_cout[i]), 32'(m_cout[i]));
        if (m_left[i] == 0)
          chk($sformatf("cyc_sum[%0d]", i), 32'(obs_sum[i]), 32'(m_sum[i]));
      end
    end
  end

  task automatic scramble(input int i);
    a_in[i] = 8'($urandom);
    b_in[i] = 8'($urandom);
    c_in[i] = 1'($urandom);
  endtask

  // Issue one add and wait (bounded) for DONE; lat counts cycles after the start negedge.
  task automatic run_add(input int i, input logic [7:0] a, input logic [7:0] b, input logic c,
                         output logic [8:0] res, output int lat);
    @(negedge clk);
    start[i] = 1'b1;
    a_in[i]  = a;
    b_in[i]  = b;
    c_in[i]  = c;
    lat = -1;
    res = '0;
    for (int j = 1; j <= wid(i) + 6; j++) begin
      @(negedge clk);
      if (j == 1) begin
        start[i] = 1'b0;
        scramble(i);
      end
      if (obs_done[i]) begin
        lat = j;
        res = {obs_cout[i], obs_sum[i]};
        break;
      end
    end
    chk($sformatf("latency[%0d]", i), 32'(lat), 32'(wid(i) + 1));
  endtask

  logic [8:0] res, res2;
  int         lat, dcnt, d1, d2;
  logic [2:0] tt_in  [8];
  logic [1:0] tt_exp [8];

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; start[i] = 1'b0; a_in[i] = '0; b_in[i] = '0; c_in[i] = 1'b0;
    end
    @(posedge clk);
    #2 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(busy8), 0);
    chk("rst_done", 32'(done8), 0);
    chk("rst_sum", 32'(sum8), 0);
    chk("rst_cout", 32'(cout8), 0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    run_add(0, 8'h00, 8'h00, 1'b0, res, lat);
    chk("zero_add", 32'(res), 32'h000);
    run_add(0, 8'hFF, 8'h01, 1'b0, res, lat);
    chk("ff_plus_1", 32'(res), 32'h100);
    run_add(0, 8'hA5, 8'h5A, 1'b1, res, lat);
    chk("a5_5a_c1", 32'(res), 32'h100);
    run_add(0, 8'd100, 8'd27, 1'b0, res, lat);
    chk("100_27", 32'(res), 32'h07F);

    // WIDTH=1 truth table, inputs as {C_IN, A_IN, B_IN}
    tt_in  = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};
    tt_exp = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int t = 0; t < 8; t++) begin
      run_add(1, {7'd0, tt_in[t][1]}, {7'd0, tt_in[t][0]}, tt_in[t][2], res, lat);
      chk($sformatf("w1_tt%0d", t), 32'({res[8], res[0]}), 32'(tt_exp[t]));
    end

    // START pulsed at cycle k+3 of a running add must be ignored
    @(negedge clk);
    start[0] = 1'b1; a_in[0] = 8'h12; b_in[0] = 8'h34; c_in[0] = 1'b0;
    dcnt = 0; d1 = -1; res = '0;
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      start[0] = (j == 3);
      if (j == 3) begin a_in[0] = 8'h77; b_in[0] = 8'h77; end
      if (done8) begin dcnt++; d1 = j; res = {cout8, sum8}; end
    end
    chk("ign_dones", 32'(dcnt), 1);
    chk("ign_lat", 32'(d1), 9);
    chk("ign_res", 32'(res), 32'h046);

    // START held through FIN: back-to-back adds every WIDTH+1 cycles
    @(negedge clk);
    start[0] = 1'b1; a_in[0] = 8'h80; b_in[0] = 8'h80; c_in[0] = 1'b1;
    d1 = -1; d2 = -1; res = '0; res2 = '0;
    for (int j = 1; j <= 24; j++) begin
      @(negedge clk);
      if (j == 3) begin a_in[0] = 8'h3C; b_in[0] = 8'h0F; c_in[0] = 1'b0; end
      if (j == 10) start[0] = 1'b0;
      if (done8 && d1 < 0) begin d1 = j; res = {cout8, sum8}; end
      else if (done8) begin d2 = j; res2 = {cout8, sum8}; end
    end
    chk("b2b_d1", 32'(d1), 9);
    chk("b2b_d2", 32'(d2), 18);
    chk("b2b_res1", 32'(res), 32'h101);
    chk("b2b_res2", 32'(res2), 32'h04B);

    // Reset in the middle of FF+FF
    @(negedge clk);
    start[0] = 1'b1; a_in[0] = 8'hFF; b_in[0] = 8'hFF; c_in[0] = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 1) start[0] = 1'b0;
      if (j == 4) rst[0] = 1'b1;
      if (j == 5) rst[0] = 1'b0;
    end
    chk("mrst_busy", 32'(busy8), 0);
    chk("mrst_done", 32'(done8), 0);
    chk("mrst_sum", 32'(sum8), 0);
    chk("mrst_cout", 32'(cout8), 0);
    run_add(0, 8'h0F, 8'h01, 1'b0, res, lat);
    chk("post_rst", 32'(res), 32'h010);

    for (int n = 0; n < 500; n++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      run_add(0, ra, rb, rc, res, lat);
      chk("rand_sum", 32'(res), 32'({1'b0, ra} + {1'b0, rb} + {8'd0, rc}));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
